mux_n_stream: RTL and testbench



---
 rtl/mux_stream_pkg.sv | 13 +
 rtl/mux_n_comb.sv | 25 ++
 rtl/mux_n_stream.sv | 162 ++++++++++++++++
 tb/tb_mux_n_stream.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// rtl/mux_stream_pkg.sv - shared FSM state and mode encodings for mux_n_stream
package mux_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational NUM_IN:1 word select with out-of-range flag
module mux_n_comb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [IDX_W-1:0]        idx,
  output logic [WIDTH-1:0]        data,
  output logic                    oor
);

  // Compare against every legal index so non-power-of-two counts yield zero and a flag
  always_comb begin
    data = '0;
    oor  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == IDX_W'(i)) begin
        data = in_bus[i*WIDTH +: WIDTH];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// rtl/mux_n_stream.sv - registered N:1 channel select / bus scan stream (optional MUX_STREAM_PARITY_EN)
module mux_n_stream
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    sel_err
`ifdef MUX_STREAM_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    sel_err_q, sel_err_d;
  logic [SEL_W-1:0]        cnt_q, cnt_d;
  logic [NUM_IN*WIDTH-1:0] shadow_q, shadow_d;
  logic                    accept;

  logic [NUM_IN*WIDTH-1:0] mux_bus;
  logic [SEL_W-1:0]        mux_idx;
  logic [WIDTH-1:0]        mux_data;
  logic                    mux_oor;

  // One shared selector: live bus on accept, frozen snapshot while scanning
  always_comb begin
    mux_bus = in_bus;
    mux_idx = sel;
    if (state_q == SCAN) begin
      mux_bus = shadow_q;
      mux_idx = cnt_q + SEL_W'(1);
    end else if (mode == MODE_SCAN) begin
      mux_idx = '0;
    end
  end

  mux_n_comb #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .IDX_W (SEL_W)
  ) u_mux (
    .in_bus(mux_bus),
    .idx   (mux_idx),
    .data  (mux_data),
    .oor   (mux_oor)
  );

  // Next-state and output-register update; everything holds unless a transfer happens
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sel_err_d   = sel_err_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;

    case (state_q)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      if (mode == MODE_SCAN) begin
        shadow_d   = in_bus;
        cnt_d      = '0;
        out_last_d = (NUM_IN == 1);
        sel_err_d  = 1'b0;
        state_d    = SCAN;
      end else begin
        out_last_d = 1'b1;
        sel_err_d  = mux_oor;
        state_d    = HOLD;
      end
    end else if (out_ready) begin
      case (state_q)
        HOLD: begin
          out_valid_d = 1'b0;
          sel_err_d   = 1'b0;
          state_d     = IDLE;
        end
        SCAN: begin
          if (cnt_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d      = cnt_q + SEL_W'(1);
            out_data_d = mux_data;
            out_last_d = ((cnt_q + SEL_W'(1)) == LAST_IDX);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset aborts any scan immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      cnt_q       <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sel_err_q   <= sel_err_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_STREAM_PARITY_EN
  logic parity_q;

  // Parity tracks the word being registered, so it always matches out_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out_data_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// tb/tb_mux_n_stream.sv - scoreboard bench for mux_n_stream (select, backpressure, range, scan, reset, parity)
module tb_mux_n_stream;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q8[$];
  exp_t q6[$];
  exp_t q4[$];
  exp_t e;

  // instance A: NUM_IN=8
  logic [8*32-1:0] a_in_bus;
  logic [2:0]      a_sel;
  logic            a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_sel_err;
  logic [31:0]     a_out_data;
  // instance B: NUM_IN=6
  logic [6*32-1:0] b_in_bus;
  logic [2:0]      b_sel;
  logic            b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_sel_err;
  logic [31:0]     b_out_data;
  // instance C: NUM_IN=4
  logic [4*32-1:0] c_in_bus;
  logic [1:0]      c_sel;
  logic            c_mode, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_sel_err;
  logic [31:0]     c_out_data;
`ifdef MUX_STREAM_PARITY_EN
  logic            a_out_parity, b_out_parity, c_out_parity;
`endif

  mux_n_stream #(.WIDTH(32), .NUM_IN(8)) u_a (
    .clk(clk), .reset(reset), .in_bus(a_in_bus), .sel(a_sel), .mode(a_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .sel_err(a_sel_err)
`ifdef MUX_STREAM_PARITY_EN
    , .out_parity(a_out_parity)
`endif
  );

  mux_n_stream #(.WIDTH(32), .NUM_IN(6)) u_b (
    .clk(clk), .reset(reset), .in_bus(b_in_bus), .sel(b_sel), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .sel_err(b_sel_err)
`ifdef MUX_STREAM_PARITY_EN
    , .out_parity(b_out_parity)
`endif
  );

  mux_n_stream #(.WIDTH(32), .NUM_IN(4)) u_c (
    .clk(clk), .reset(reset), .in_bus(c_in_bus), .sel(c_sel), .mode(c_mode),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last),
    .sel_err(c_sel_err)
`ifdef MUX_STREAM_PARITY_EN
    , .out_parity(c_out_parity)
`endif
  );

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) a_in_bus[i*32 +: 32] = 32'hA0 + i;
    for (int i = 0; i < 6; i++) b_in_bus[i*32 +: 32] = 32'hA0 + i;
    c_in_bus = {32'hD, 32'hC, 32'hB, 32'hA};
    {a_sel, a_mode, a_in_valid, a_out_ready} = '0;
    {b_sel, b_mode, b_in_valid, b_out_ready} = '0;
    {c_sel, c_mode, c_in_valid, c_out_ready} = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_last, a_sel_err, a_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_a got v=%b d=%h l=%b e=%b r=%b exp 0/0/0/0/1", a_out_valid, a_out_data, a_out_last, a_sel_err, a_in_ready);
    else n_pass++;
    n_checks++;
    if ({b_out_valid, b_out_data, b_out_last, b_sel_err, b_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_b got v=%b d=%h l=%b e=%b r=%b exp 0/0/0/0/1", b_out_valid, b_out_data, b_out_last, b_sel_err, b_in_ready);
    else n_pass++;
    n_checks++;
    if ({c_out_valid, c_out_data, c_out_last, c_sel_err, c_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_c got v=%b d=%h l=%b e=%b r=%b exp 0/0/0/0/1", c_out_valid, c_out_data, c_out_last, c_sel_err, c_in_ready);
    else n_pass++;
`ifdef MUX_STREAM_PARITY_EN
    n_checks++;
    if (a_out_parity !== 1'b0) $display("FAIL reset_parity got %b exp 0", a_out_parity);
    else n_pass++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_select_sweep();
    a_out_ready = 1'b1;
    a_mode      = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        a_in_valid = 1'b1;
        a_sel      = 3'(i);
        q8.push_back('{data: 32'hA0 + i, last: 1'b1, err: 1'b0});
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        e = q8.pop_front();
        n_checks++;
        if ({a_out_valid, a_out_data, a_out_last, a_sel_err} !== {1'b1, e.data, e.last, e.err})
          $display("FAIL sweep[%0d] got v=%b d=%h l=%b e=%b exp v=1 d=%h l=%b e=%b",
                   i - 1, a_out_valid, a_out_data, a_out_last, a_sel_err, e.data, e.last, e.err);
        else n_pass++;
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01)
      $display("FAIL sweep_idle got v=%b r=%b exp v=0 r=1", a_out_valid, a_in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a_mode = 1'b0; a_sel = 3'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    q8.push_back('{data: 32'hA3, last: 1'b1, err: 1'b0});
    @(negedge clk);
    a_sel = 3'd5; a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, q8[0].data, 1'b0})
        $display("FAIL b2b_stall[%0d] got v=%b d=%h r=%b exp v=1 d=%h r=0", k, a_out_valid, a_out_data, a_in_ready, q8[0].data);
      else n_pass++;
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    #1;
    e = q8.pop_front();
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_last, a_in_ready} !== {1'b1, e.data, e.last, 1'b1})
      $display("FAIL b2b_release got v=%b d=%h l=%b r=%b exp v=1 d=%h l=%b r=1", a_out_valid, a_out_data, a_out_last, a_in_ready, e.data, e.last);
    else n_pass++;
    q8.push_back('{data: 32'hA5, last: 1'b1, err: 1'b0});
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    e = q8.pop_front();
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, e.data, e.last})
      $display("FAIL b2b_second got v=%b d=%h l=%b exp v=1 d=%h l=%b", a_out_valid, a_out_data, a_out_last, e.data, e.last);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01)
      $display("FAIL b2b_idle got v=%b r=%b exp v=0 r=1", a_out_valid, a_in_ready);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [2:0] sels [2];
    sels[0] = 3'd7;
    sels[1] = 3'd2;
    b_out_ready = 1'b1;
    b_mode      = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i < 2) begin
        b_in_valid = 1'b1;
        b_sel      = sels[i];
        if (sels[i] >= 3'd6) q6.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
        else                 q6.push_back('{data: 32'hA0 + 32'(sels[i]), last: 1'b1, err: 1'b0});
      end else begin
        b_in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        e = q6.pop_front();
        n_checks++;
        if ({b_out_valid, b_out_data, b_out_last, b_sel_err} !== {1'b1, e.data, e.last, e.err})
          $display("FAIL range[%0d] got v=%b d=%h l=%b e=%b exp v=1 d=%h l=%b e=%b",
                   i - 1, b_out_valid, b_out_data, b_out_last, b_sel_err, e.data, e.last, e.err);
        else n_pass++;
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({b_out_valid, b_sel_err} !== 2'b00)
      $display("FAIL range_idle got v=%b e=%b exp 0/0", b_out_valid, b_sel_err);
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [31:0] ch [4];
    ch[0] = 32'hA; ch[1] = 32'hB; ch[2] = 32'hC; ch[3] = 32'hD;
    @(negedge clk);
    c_in_bus = {ch[3], ch[2], ch[1], ch[0]};
    c_mode = 1'b1; c_sel = 2'd3; c_in_valid = 1'b1; c_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) q4.push_back('{data: ch[k], last: (k == 3), err: 1'b0});
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      c_in_valid  = 1'b0;
      c_in_bus    = {4{32'hDEAD_BEEF}};
      c_out_ready = !(cyc == 2 || cyc == 3);
      #1;
      if (cyc == 7) begin
        n_checks++;
        if ({c_out_valid, c_in_ready} !== 2'b01)
          $display("FAIL scan_idle got v=%b r=%b exp v=0 r=1", c_out_valid, c_in_ready);
        else n_pass++;
      end else begin
        if (c_out_ready) e = q4.pop_front();
        else             e = q4[0];
        n_checks++;
        if ({c_out_valid, c_out_data, c_out_last, c_in_ready} !== {1'b1, e.data, e.last, 1'b0})
          $display("FAIL scan[%0d] got v=%b d=%h l=%b r=%b exp v=1 d=%h l=%b r=0",
                   cyc, c_out_valid, c_out_data, c_out_last, c_in_ready, e.data, e.last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] ch [4];
    ch[0] = 32'h10; ch[1] = 32'h11; ch[2] = 32'h12; ch[3] = 32'h13;
    @(negedge clk);
    c_in_bus = {ch[3], ch[2], ch[1], ch[0]};
    c_mode = 1'b1; c_in_valid = 1'b1; c_out_ready = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_data} !== {1'b1, ch[0]})
      $display("FAIL rst_scan_w0 got v=%b d=%h exp v=1 d=%h", c_out_valid, c_out_data, ch[0]);
    else n_pass++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_data, c_out_last} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL rst_async got v=%b d=%h l=%b exp 0/0/0", c_out_valid, c_out_data, c_out_last);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({c_out_valid, c_in_ready} !== 2'b01)
      $display("FAIL rst_release got v=%b r=%b exp v=0 r=1", c_out_valid, c_in_ready);
    else n_pass++;
    q4.delete();
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        c_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) q4.push_back('{data: ch[k], last: (k == 3), err: 1'b0});
      end else begin
        c_in_valid = 1'b0;
      end
      #1;
      if (i == 5) begin
        n_checks++;
        if (c_out_valid !== 1'b0) $display("FAIL rescan_end got v=%b exp 0", c_out_valid);
        else n_pass++;
      end else if (i > 0) begin
        e = q4.pop_front();
        n_checks++;
        if ({c_out_valid, c_out_data, c_out_last} !== {1'b1, e.data, e.last})
          $display("FAIL rescan[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   i - 1, c_out_valid, c_out_data, c_out_last, e.data, e.last);
        else n_pass++;
      end
    end
  endtask

`ifdef MUX_STREAM_PARITY_EN
  task automatic test_parity();
    logic exp_p [2];
    exp_p[0] = 1'b1;
    exp_p[1] = 1'b0;
    a_in_bus[0*32 +: 32] = 32'h0000_0001;
    a_in_bus[1*32 +: 32] = 32'h0000_0003;
    a_mode = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i < 2) begin
        a_in_valid = 1'b1;
        a_sel      = 3'(i);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        n_checks++;
        if ({a_out_valid, a_out_parity} !== {1'b1, exp_p[i-1]})
          $display("FAIL parity[%0d] got v=%b p=%b exp v=1 p=%b", i - 1, a_out_valid, a_out_parity, exp_p[i-1]);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_select_sweep();
    test_back_to_back();
    test_out_of_range();
    test_scan();
    test_reset_mid_scan();
`ifdef MUX_STREAM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
